// File: rtl/ad1_decimator.sv
// ad1_decimator
//   Block-averaging decimator for a 16-bit unsigned ADC stream with an output
//   FIFO. Each rising edge of din_drdy (while enabled) is one sample; every
//   2**DECIM_LOG2 samples the truncated mean is pushed into a first-word
//   fall-through FIFO.
//
// Ports
//   clk_100M    : clock, all state updates on its rising edge
//   rst         : synchronous active-high reset
//   enable      : sample acceptance gate; low discards any partial block
//   din_drdy    : ADC data-ready level (may stay high for several cycles)
//   din         : ADC sample, stable while din_drdy is high
//   dout        : FIFO head (zero while the FIFO is empty)
//   dout_valid  : FIFO non-empty
//   dout_ready  : consumer accept; pops when dout_valid is also high
//   fifo_level  : FIFO occupancy
//   overflow    : sticky flag, set when a finished average is dropped
//   clr_ovf     : clears overflow (a simultaneous drop wins)

module ad1_decimator #(
    parameter int unsigned DECIM_LOG2 = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_100M,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          din_drdy,
    input  logic [15:0]                   din,
    output logic [15:0]                   dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int unsigned AW = 16 + DECIM_LOG2;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    logic          drdy_q;
    logic          sample_evt;
    logic          block_done;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [15:0]   avg;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          drop;

    // One event per upstream sample: the rising edge of the ready level.
    assign sample_evt = din_drdy & ~drdy_q & enable;

    // acc is wide enough for 2**DECIM_LOG2 full-scale samples, so no wrap.
    assign sum = acc + AW'(din);
    assign avg = sum[AW-1:DECIM_LOG2];

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            drdy_q <= 1'b0;
        end else begin
            drdy_q <= din_drdy;
        end
    end

    // Sample counter; with no decimation every event completes a block.
    if (DECIM_LOG2 > 0) begin : g_cnt
        logic [DECIM_LOG2-1:0] cnt;

        always_ff @(posedge clk_100M) begin
            if (rst || !enable) begin
                cnt <= '0;
            end else if (sample_evt) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign block_done = &cnt;
    end else begin : g_nocnt
        assign block_done = 1'b1;
    end

    always_ff @(posedge clk_100M) begin
        if (rst || !enable) begin
            acc <= '0;
        end else if (sample_evt) begin
            acc <= block_done ? '0 : sum;
        end
    end

    // FIFO control: a push into a full FIFO only succeeds alongside a pop.
    assign push  = sample_evt & block_done;
    assign pop   = dout_valid & dout_ready;
    assign full  = (fifo_level == LW'(FIFO_DEPTH));
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk_100M) begin
        if (wr_en) begin
            mem[wr_ptr] <= avg;
        end
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // First-word fall-through head; forced to zero when empty so the
    // outputs read as zero after reset.
    assign dout_valid = (fifo_level != '0);
    assign dout       = dout_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ad1_decimator.sv
// tb_ad1_decimator
//   Self-checking bench for ad1_decimator (DECIM_LOG2=2, FIFO_DEPTH=8).
//   A behavioural model (sample list per block, queue for the FIFO) predicts
//   dout, dout_valid, fifo_level and overflow after every clock edge.

module tb_ad1_decimator;

    localparam int unsigned D     = 2;
    localparam int unsigned DEPTH = 8;
    localparam int          N     = 1 << D;

    logic        clk_100M = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        din_drdy = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [$clog2(DEPTH):0] fifo_level;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_samples[$];
    int exp_q[$];
    bit m_prev = 1'b0;
    bit m_ovf  = 1'b0;

    ad1_decimator #(
        .DECIM_LOG2 (D),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_100M   (clk_100M),
        .rst        (rst),
        .enable     (enable),
        .din_drdy   (din_drdy),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Predict the effect of the coming edge from the current inputs.
    task automatic model_edge();
        bit ev;
        bit pushing;
        bit pop;
        bit full;
        int avg;
        int s;
        pushing = 1'b0;
        avg     = 0;
        if (rst) begin
            m_samples.delete();
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            ev   = din_drdy && !m_prev && enable;
            pop  = (exp_q.size() > 0) && dout_ready;
            full = (exp_q.size() == DEPTH);
            if (!enable) m_samples.delete();
            if (ev) begin
                m_samples.push_back(int'(din));
                if (m_samples.size() == N) begin
                    s = 0;
                    foreach (m_samples[k]) s += m_samples[k];
                    avg = s / N;
                    pushing = 1'b1;
                    m_samples.delete();
                end
            end
            if (pop) void'(exp_q.pop_front());
            if (pushing && (!full || pop)) exp_q.push_back(avg);
            if (pushing && full && !pop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
        m_prev = rst ? 1'b0 : din_drdy;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_100M);
        #1;
        check_val("dout_valid", dout_valid, exp_q.size() > 0);
        check_val("fifo_level", fifo_level, exp_q.size());
        check_val("overflow", overflow, m_ovf);
        check_val("dout", dout, (exp_q.size() > 0) ? exp_q[0] : 0);
    endtask

    task automatic send(input int v, input int hi, input int lo);
        din      = 16'(v);
        din_drdy = 1'b1;
        repeat (hi) step();
        din_drdy = 1'b0;
        repeat (lo) step();
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        repeat (DEPTH + 2) step();
        dout_ready = 1'b0;
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check_val("rst_level", fifo_level, 0);
        check_val("rst_valid", dout_valid, 0);
        rst    = 1'b0;
        enable = 1'b1;
        step();

        // Basic average with long drdy high time; latency of the 4th event
        send(100, 5, 2);
        send(200, 5, 2);
        send(300, 5, 2);
        check_val("avg250_pre_valid", dout_valid, 0);
        din = 16'd401; din_drdy = 1'b1;
        step();
        check_val("avg250_lat_valid", dout_valid, 1);
        check_val("avg250_dout", dout, 250);
        check_val("avg250_level", fifo_level, 1);
        repeat (4) step();
        din_drdy = 1'b0;
        step();
        check_val("avg250_single", fifo_level, 1);
        drain();

        // Full scale (no wrap) and truncation
        repeat (4) send(16'hFFFF, 2, 1);
        check_val("fullscale", dout, 16'hFFFF);
        drain();
        send(1, 1, 1); send(1, 1, 1); send(1, 1, 1); send(0, 1, 1);
        check_val("trunc", dout, 0);
        check_val("trunc_valid", dout_valid, 1);
        drain();

        // Overflow: 9 blocks with no consumer, then read back in order
        for (int b = 0; b < 9; b++)
            for (int j = 0; j < N; j++) send(1000 * (b + 1) + j, 1, 1);
        check_val("ovf_level", fifo_level, DEPTH);
        check_val("ovf_flag", overflow, 1);
        dout_ready = 1'b1;
        for (int b = 0; b < DEPTH; b++) begin
            check_val("ovf_order", dout, 1000 * (b + 1) + 1);
            step();
        end
        dout_ready = 1'b0;
        check_val("ovf_empty", dout_valid, 0);
        check_val("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check_val("ovf_cleared", overflow, 0);

        // Full FIFO, pop on the completing edge: both succeed
        for (int b = 0; b < DEPTH; b++)
            for (int j = 0; j < N; j++) send(50 + b, 1, 1);
        check_val("full_level", fifo_level, DEPTH);
        send(7, 1, 1); send(7, 1, 1); send(7, 1, 1);
        din = 16'd7; din_drdy = 1'b1; dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        check_val("pushpop_level", fifo_level, DEPTH);
        check_val("pushpop_ovf", overflow, 0);
        check_val("pushpop_head", dout, 51);
        din_drdy = 1'b0;
        step();
        drain();

        // enable low for one cycle discards the partial block
        send(1000, 1, 1); send(2000, 1, 1);
        enable = 1'b0;
        step();
        enable = 1'b1;
        repeat (4) send(40, 2, 1);
        check_val("enable_level", fifo_level, 1);
        check_val("enable_avg", dout, 40);
        drain();

        // Reset mid-block; drdy already high across the reset release
        send(3000, 1, 1); send(3000, 1, 1); send(3000, 1, 1);
        rst = 1'b1; din = 16'd8; din_drdy = 1'b1;
        repeat (2) step();
        check_val("midrst_valid", dout_valid, 0);
        rst = 1'b0;
        step();
        din_drdy = 1'b0;
        step();
        send(8, 1, 1); send(8, 1, 1); send(8, 1, 1);
        check_val("midrst_level", fifo_level, 1);
        check_val("midrst_avg", dout, 8);
        drain();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            enable     = ($urandom_range(0, 15) != 0);
            dout_ready = ($urandom_range(0, 2) != 0);
            clr_ovf    = ($urandom_range(0, 31) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            send(int'($urandom_range(0, 65535)), int'($urandom_range(1, 4)),
                 int'($urandom_range(1, 3)));
        end
        rst = 1'b0; enable = 1'b1; clr_ovf = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ad1_decimator.md
AD1_DECIMATOR -- requirements
Module: ad1_decimator

Interface
REQ-001 Parameter DECIM_LOG2, default 2, SHALL set samples averaged per output as 2**DECIM_LOG2 (legal 0..8).
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set output FIFO entries (power of two, 2..64).
REQ-003 clk_100M  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 enable  input  1  SHALL gate sample acceptance; high = accept.
REQ-006 din_drdy  input  1  SHALL be the upstream ADC data-ready level; may stay high for several cycles per sample.
REQ-007 din  input  16  SHALL be the unsigned ADC sample, stable while din_drdy is high.
REQ-008 dout  output  16  SHALL be the FIFO head, an averaged sample.
REQ-009 dout_valid  output  1  SHALL be high when the FIFO is non-empty.
REQ-010 dout_ready  input  1  SHALL be the consumer accept signal.
REQ-011 fifo_level  output  $clog2(FIFO_DEPTH)+1  SHALL be the current FIFO occupancy.
REQ-012 overflow  output  1  SHALL be a sticky flag set when an average is dropped.
REQ-013 clr_ovf  input  1  SHALL clear overflow.

Function
REQ-014 A registered copy drdy_q SHALL be kept; a sample event SHALL be the cycle with din_drdy=1, drdy_q=0 and enable=1; one event per upstream sample, regardless of high-time length.
REQ-015 Accumulator acc SHALL be 16+DECIM_LOG2 bits unsigned, with no overflow possible; sample counter cnt SHALL be DECIM_LOG2 bits wide (absent when DECIM_LOG2=0).
REQ-016 On an event with cnt < 2**DECIM_LOG2-1: acc <= acc+din, cnt <= cnt+1.
REQ-017 On an event with cnt = 2**DECIM_LOG2-1: (acc+din)>>DECIM_LOG2 (truncating) SHALL be pushed to the FIFO on that edge; acc <= 0, cnt <= 0.
REQ-018 Latency: dout_valid (empty FIFO) SHALL rise the cycle after the completing event's edge, with dout equal to the pushed average (first-word fall-through).
REQ-019 Pop SHALL occur on an edge with dout_valid=1 and dout_ready=1; dout_ready with dout_valid=0 SHALL have no effect.
REQ-020 Push when full without simultaneous pop: the average SHALL be dropped, FIFO unchanged, overflow <= 1.
REQ-021 Push and pop on the same edge when full SHALL both succeed; fifo_level unchanged, overflow unchanged.
REQ-022 Push and pop on the same edge when not full and not empty SHALL leave fifo_level unchanged and keep order.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH; data SHALL emerge strictly in push order.
REQ-024 enable=0 SHALL suppress events; the cycle enable is sampled 0, acc and cnt SHALL clear (partial block discarded); FIFO contents and handshake unaffected.
REQ-025 clr_ovf=1 SHALL clear overflow on that edge; if a drop occurs on the same edge, overflow SHALL end 1 (set wins).
REQ-026 drdy_q SHALL update every cycle independent of enable, so a level already high when enable rises SHALL NOT create an event.

Reset
REQ-027 With rst=1 at an edge: acc=0, cnt=0, drdy_q=0, FIFO pointers=0, fifo_level=0, dout_valid=0, dout=0, overflow=0; rst SHALL take priority over all other inputs.
REQ-028 Reset mid-block SHALL discard the partial sum; first event after reset SHALL start a new block with cnt=0.
REQ-029 If din_drdy is high during the rst release cycle, the first cycle after reset SHALL register it as an event (drdy_q=0).

Verification
REQ-030 DECIM_LOG2=2, samples 100,200,300,401, drdy high 5 cycles each -> one output 250, dout_valid one cycle after 4th rise, fifo_level=1.
REQ-031 Samples 0xFFFF x4 -> dout=0xFFFF (no wrap); samples 1,1,1,0 -> dout=0 (truncation).
REQ-032 dout_ready=0, 9 complete blocks, FIFO_DEPTH=8 -> fifo_level=8, overflow=1, first 8 averages read back in order; clr_ovf pulse -> overflow=0.
REQ-033 FIFO full, dout_ready=1 on the edge of a completing event -> pop and push both occur, fifo_level stays 8, overflow stays 0.
REQ-034 Two samples, then enable=0 for 1 cycle, then 4 samples of 40 -> single output 40.
REQ-035 rst asserted after 3 samples, then 4 samples of 8 -> single output 8; all outputs at reset values during rst.
